// File: rtl/car_pedal_conditioner.sv
// car_pedal_conditioner: debounces key, brake and accelerator switches and applies
// start-up interlocks before driving car_speed_cntl.
// Optional feature macro: CAR_PEDAL_SYNC_EN. When defined, each raw input passes a
// 2-flop synchronizer ahead of its debounce filter, which adds 2 edges of latency.
module car_pedal_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic keys_raw,
  input  logic brake_raw,
  input  logic accel_raw,
  output logic keys,
  output logic brake,
  output logic accelerate,
  output logic conflict,
  output logic armed_wait
);

  localparam int NUM_CH = 3;
  localparam int CH_K   = 0;
  localparam int CH_B   = 1;
  localparam int CH_A   = 2;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } state_t;

  logic [NUM_CH-1:0] raw_w;
  logic [NUM_CH-1:0] samp_w;
  logic [NUM_CH-1:0] db_w;

  assign raw_w = {accel_raw, brake_raw, keys_raw};

`ifdef CAR_PEDAL_SYNC_EN
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  // Two-flop synchronizer per channel; filters sample the second stage.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  assign samp_w = sync2_q;
`else
  assign samp_w = raw_w;
`endif

  // One independent debounce filter per channel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             stable_q;
      logic             stable_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Count consecutive differing samples; accept the new level on the Nth one.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (samp_w[gi] == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = samp_w[gi];
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Filter state register; reset discards any partial count.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign db_w[gi] = stable_q;
    end
  endgenerate

  logic k_db;
  logic b_db;
  logic a_db;

  assign k_db = db_w[CH_K];
  assign b_db = db_w[CH_B];
  assign a_db = db_w[CH_A];

  state_t state_q;
  state_t state_d;

  logic keys_q,  keys_d;
  logic brake_q, brake_d;
  logic accel_q, accel_d;
  logic confl_q, confl_d;
  logic armed_q, armed_d;

  // Next-state and output decode. Outputs are derived from the next state so that
  // key removal drops accelerate on the same edge that keys falls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (k_db && a_db) state_d = ST_ARM;
        else if (k_db)    state_d = ST_RUN;
      end
      ST_ARM: begin
        if (!k_db)      state_d = ST_OFF;
        else if (!a_db) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!k_db) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    keys_d  = k_db;
    brake_d = b_db;
    accel_d = a_db & ~b_db & (state_d == ST_RUN);
    confl_d = a_db & b_db;
    armed_d = (state_d == ST_ARM);
  end

  // Interlock state and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      keys_q  <= 1'b0;
      brake_q <= 1'b0;
      accel_q <= 1'b0;
      confl_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      brake_q <= brake_d;
      accel_q <= accel_d;
      confl_q <= confl_d;
      armed_q <= armed_d;
    end
  end

  assign keys       = keys_q;
  assign brake      = brake_q;
  assign accelerate = accel_q;
  assign conflict   = confl_q;
  assign armed_wait = armed_q;

endmodule

// File: tb/tb_car_pedal_conditioner.sv
// Directed testbench for car_pedal_conditioner (DEBOUNCE_CYCLES=4, 50 ns clock).
// Output vector checked as {keys, brake, accelerate, conflict, armed_wait}.
module tb_car_pedal_conditioner;

`ifdef CAR_PEDAL_SYNC_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif

  logic clock;
  logic reset_n;
  logic keys_raw, brake_raw, accel_raw;
  logic keys, brake, accelerate, conflict, armed_wait;

  int checks = 0;
  int errors = 0;

  car_pedal_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .keys_raw(keys_raw),
    .brake_raw(brake_raw),
    .accel_raw(accel_raw),
    .keys(keys),
    .brake(brake),
    .accelerate(accelerate),
    .conflict(conflict),
    .armed_wait(armed_wait)
  );

  initial clock = 1'b0;
  always #25 clock = ~clock;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {keys, brake, accelerate, conflict, armed_wait};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("t=%0t %s: out=%b exp=%b", $time, tag, obs, exp);
  endtask

  initial begin
    // Scenario 1: reset with every raw input high.
    reset_n   = 1'b0;
    keys_raw  = 1'b1;
    brake_raw = 1'b1;
    accel_raw = 1'b1;
    tick(2);
    chk("reset_all_zero", 5'b00000);
    reset_n = 1'b1;
    tick(4 + SX);
    chk("post_reset_not_yet", 5'b00000);
    tick(1);
    chk("keyon_pedals_held_arm", 5'b11011);

    // Scenario 4: release both pedals -> RUN, no accelerate yet.
    accel_raw = 1'b0;
    brake_raw = 1'b0;
    tick(4 + SX);
    chk("release_pending", 5'b11011);
    tick(1);
    chk("arm_to_run", 5'b10000);

    // Press accelerator again -> accelerate after N+1 edges.
    accel_raw = 1'b1;
    tick(4 + SX);
    chk("accel_pending", 5'b10000);
    tick(1);
    chk("accel_on", 5'b10100);

    // Scenario 3: brake while accelerating -> brake wins, conflict flagged.
    brake_raw = 1'b1;
    tick(4 + SX);
    chk("brake_pending", 5'b10100);
    tick(1);
    chk("brake_wins_conflict", 5'b11010);
    brake_raw = 1'b0;
    tick(5 + SX);
    chk("brake_release_accel", 5'b10100);

    // Scenario 5: key off mid-drive.
    keys_raw = 1'b0;
    tick(4 + SX);
    chk("keyoff_pending", 5'b10100);
    tick(1);
    chk("keyoff_all_drop", 5'b00000);

    // Key back on with accelerator still held -> interlock ARM.
    keys_raw = 1'b1;
    tick(5 + SX);
    chk("rekey_accel_held_arm", 5'b10001);
    accel_raw = 1'b0;
    tick(5 + SX);
    chk("rekey_release_run", 5'b10000);

    // Short key-off glitch (3 edges) is rejected.
    keys_raw = 1'b0;
    tick(3);
    keys_raw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick(1);
      chk("keyoff_glitch_reject", 5'b10000);
    end

    // Scenario 2 from a clean reset: 3-edge pulse rejected.
    reset_n  = 1'b0;
    keys_raw = 1'b0;
    tick(1);
    chk("reset2", 5'b00000);
    reset_n  = 1'b1;
    keys_raw = 1'b1;
    tick(3);
    keys_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      chk("glitch3_reject", 5'b00000);
    end

    // 4-edge pulse -> keys high for exactly 4 edges.
    keys_raw = 1'b1;
    tick(4);
    keys_raw = 1'b0;
    for (int e = 5; e <= 14; e++) begin
      tick(1);
      if (e >= 5 + SX && e <= 8 + SX)
        chk("pulse4_high", 5'b10000);
      else
        chk("pulse4_low", 5'b00000);
    end

    // Reset mid-debounce discards the partial count.
    keys_raw = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(4 + SX);
    chk("reset_mid_count_restart", 5'b00000);
    tick(1);
    chk("reset_mid_count_keys", 5'b10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
